// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer and the bus encoder.
// Holds the opcode values, the bus source bit indices and the sequencer
// state type.
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_LD   = 5'h00;
    localparam logic [4:0] OP_ST   = 5'h02;
    localparam logic [4:0] OP_ADD  = 5'h03;
    localparam logic [4:0] OP_SUB  = 5'h04;
    localparam logic [4:0] OP_AND  = 5'h05;
    localparam logic [4:0] OP_OR   = 5'h06;
    localparam logic [4:0] OP_MOVE = 5'h0A;
    localparam logic [4:0] OP_NOP  = 5'h1E;
    localparam logic [4:0] OP_HALT = 5'h1F;

    // Bus source indices; bits 15:0 are R0..R15.
    localparam int BUS_HI     = 16;
    localparam int BUS_LO     = 17;
    localparam int BUS_ZHIGH  = 18;
    localparam int BUS_ZLOW   = 19;
    localparam int BUS_PC     = 20;
    localparam int BUS_MDR    = 21;
    localparam int BUS_INPORT = 22;
    localparam int BUS_C      = 23;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_T0,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_HALTED
    } seq_state_t;

    function automatic logic is_alu_op(input logic [4:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Connection between the control sequencer and the datapath.
//   master: sequencer side (takes run/IR fields/mem_done, drives strobes)
//   slave : datapath side
// Signals: run, ir_opcode/ir_ra/ir_rb/ir_rc, mem_done in; bus_src, reg_in,
// load strobes, mem_read/mem_write, alu_op, illegal_op, mem_timeout, halted out.
interface control_sequencer_if;
    logic        run;
    logic [4:0]  ir_opcode;
    logic [3:0]  ir_ra;
    logic [3:0]  ir_rb;
    logic [3:0]  ir_rc;
    logic        mem_done;
    logic [23:0] bus_src;
    logic [15:0] reg_in;
    logic        pc_in;
    logic        inc_pc;
    logic        mar_in;
    logic        mdr_in;
    logic        ir_in;
    logic        y_in;
    logic        z_in;
    logic        mem_read;
    logic        mem_write;
    logic [4:0]  alu_op;
    logic        illegal_op;
    logic        mem_timeout;
    logic        halted;

    modport master (
        input  run, ir_opcode, ir_ra, ir_rb, ir_rc, mem_done,
        output bus_src, reg_in, pc_in, inc_pc, mar_in, mdr_in, ir_in, y_in, z_in,
               mem_read, mem_write, alu_op, illegal_op, mem_timeout, halted
    );

    modport slave (
        output run, ir_opcode, ir_ra, ir_rb, ir_rc, mem_done,
        input  bus_src, reg_in, pc_in, inc_pc, mar_in, mdr_in, ir_in, y_in, z_in,
               mem_read, mem_write, alu_op, illegal_op, mem_timeout, halted
    );
endinterface

// File: rtl/gpr_onehot_decoder.sv
// 4-bit register index to 16-bit one-hot select, all zero when en=0.
// Ports: idx (register number), en (select enable), onehot (R0..R15 select).
module gpr_onehot_decoder (
    input  logic [3:0]  idx,
    input  logic        en,
    output logic [15:0] onehot
);
    always_comb begin
        onehot = '0;
        if (en) onehot[idx] = 1'b1;
    end
endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute control-step sequencer. Walks T0..T5 and issues the
// one-hot bus source vector plus register-load, ALU and memory strobes.
// Ports: clk, rst_n (async, active-low), ctrl (control_sequencer_if.master).
// Parameter MEM_WAIT_MAX: cycles a memory access may wait for mem_done.
//
// state     | meaning
// ST_IDLE   | parked, waiting for run
// ST_T0     | PC -> MAR, increment PC into Z
// ST_T1     | Zlow -> PC, instruction read, wait mem_done
// ST_T2     | MDR -> IR
// ST_T3     | execute step 1 (decode by opcode)
// ST_T4     | execute step 2 (LD waits mem_done here)
// ST_T5     | execute step 3 (ST waits mem_done here)
// ST_HALTED | stopped until reset
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    control_sequencer_if.master ctrl
);
    seq_state_t  state;
    seq_state_t  instr_done_state;
    logic [7:0]  wait_cnt;
    logic        mem_timeout_q;
    logic        op_alu, op_ld, op_st, op_move, op_nop, op_halt, op_known;
    logic        in_wait, wait_expired;
    logic [23:0] bus_special;
    logic [3:0]  gpr_idx;
    logic        gpr_src_en, gpr_load_en;
    logic [15:0] gpr_bus, gpr_load;

    assign op_alu   = is_alu_op(ctrl.ir_opcode);
    assign op_ld    = (ctrl.ir_opcode == OP_LD);
    assign op_st    = (ctrl.ir_opcode == OP_ST);
    assign op_move  = (ctrl.ir_opcode == OP_MOVE);
    assign op_nop   = (ctrl.ir_opcode == OP_NOP);
    assign op_halt  = (ctrl.ir_opcode == OP_HALT);
    assign op_known = op_alu | op_ld | op_st | op_move | op_nop | op_halt;

    assign in_wait = (state == ST_T1) || ((state == ST_T4) && op_ld) || ((state == ST_T5) && op_st);
    assign wait_expired = in_wait && !ctrl.mem_done && (wait_cnt >= 8'(MEM_WAIT_MAX - 1));
    assign instr_done_state = ctrl.run ? ST_T0 : ST_IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            wait_cnt      <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            mem_timeout_q <= 1'b0;
            // Held at zero outside wait states, so every wait starts from zero.
            if (!in_wait)
                wait_cnt <= '0;
            else if (!ctrl.mem_done && (wait_cnt != 8'hFF))
                wait_cnt <= wait_cnt + 8'd1;

            if (wait_expired) begin
                state         <= ST_IDLE;
                mem_timeout_q <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE:   if (ctrl.run) state <= ST_T0;
                    ST_T0:     state <= ST_T1;
                    ST_T1:     if (ctrl.mem_done) state <= ST_T2;
                    ST_T2:     state <= ST_T3;
                    ST_T3: begin
                        if (op_halt)
                            state <= ST_HALTED;
                        else if (op_alu || op_ld || op_st)
                            state <= ST_T4;
                        else
                            state <= instr_done_state;
                    end
                    ST_T4:     if (!op_ld || ctrl.mem_done) state <= ST_T5;
                    ST_T5:     if (!op_st || ctrl.mem_done) state <= instr_done_state;
                    ST_HALTED: state <= ST_HALTED;
                    default:   state <= ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        bus_special     = '0;
        gpr_idx         = ctrl.ir_rb;
        gpr_src_en      = 1'b0;
        gpr_load_en     = 1'b0;
        ctrl.pc_in      = 1'b0;
        ctrl.inc_pc     = 1'b0;
        ctrl.mar_in     = 1'b0;
        ctrl.mdr_in     = 1'b0;
        ctrl.ir_in      = 1'b0;
        ctrl.y_in       = 1'b0;
        ctrl.z_in       = 1'b0;
        ctrl.mem_read   = 1'b0;
        ctrl.mem_write  = 1'b0;
        ctrl.alu_op     = '0;
        ctrl.illegal_op = 1'b0;
        ctrl.halted     = 1'b0;
        case (state)
            ST_T0: begin
                bus_special[BUS_PC] = 1'b1;
                ctrl.mar_in = 1'b1;
                ctrl.inc_pc = 1'b1;
                ctrl.z_in   = 1'b1;
            end
            ST_T1: begin
                bus_special[BUS_ZLOW] = 1'b1;
                ctrl.pc_in    = 1'b1;
                ctrl.mem_read = 1'b1;
                ctrl.mdr_in   = 1'b1;
            end
            ST_T2: begin
                bus_special[BUS_MDR] = 1'b1;
                ctrl.ir_in = 1'b1;
            end
            ST_T3: begin
                if (op_alu) begin
                    gpr_src_en = 1'b1;
                    ctrl.y_in  = 1'b1;
                end else if (op_ld || op_st) begin
                    gpr_src_en  = 1'b1;
                    ctrl.mar_in = 1'b1;
                end else if (op_move) begin
                    gpr_src_en  = 1'b1;
                    gpr_load_en = 1'b1;
                end else if (!op_known) begin
                    ctrl.illegal_op = 1'b1;
                end
            end
            ST_T4: begin
                if (op_alu) begin
                    gpr_idx     = ctrl.ir_rc;
                    gpr_src_en  = 1'b1;
                    ctrl.z_in   = 1'b1;
                    ctrl.alu_op = ctrl.ir_opcode;
                end else if (op_ld) begin
                    ctrl.mem_read = 1'b1;
                    ctrl.mdr_in   = 1'b1;
                end else if (op_st) begin
                    gpr_idx     = ctrl.ir_ra;
                    gpr_src_en  = 1'b1;
                    ctrl.mdr_in = 1'b1;
                end
            end
            ST_T5: begin
                if (op_alu) begin
                    bus_special[BUS_ZLOW] = 1'b1;
                    gpr_load_en = 1'b1;
                end else if (op_ld) begin
                    bus_special[BUS_MDR] = 1'b1;
                    gpr_load_en = 1'b1;
                end else if (op_st) begin
                    ctrl.mem_write = 1'b1;
                end
            end
            ST_HALTED: ctrl.halted = 1'b1;
            default: ;
        endcase
    end

    // Only one of bus_special / gpr_src_en is ever active in a state, keeping bus_src one-hot.
    gpr_onehot_decoder u_bus_dec (
        .idx    (gpr_idx),
        .en     (gpr_src_en),
        .onehot (gpr_bus)
    );

    gpr_onehot_decoder u_load_dec (
        .idx    (ctrl.ir_ra),
        .en     (gpr_load_en),
        .onehot (gpr_load)
    );

    assign ctrl.bus_src     = bus_special | {8'h00, gpr_bus};
    assign ctrl.reg_in      = gpr_load;
    assign ctrl.mem_timeout = mem_timeout_q;
endmodule
